// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction fetch unit: a small program memory feeding a DEPTH-entry
// instruction queue that presents its head to an execute stage through a
// valid/ready handshake. Fetching starts at address 0 on `start`, continues
// while the queue has room, and stops when the all-zero HALT word is read.
// The queue then drains to the execute stage before the unit reports HALT.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   reset      synchronous active-high reset
//   start      begin fetching at address 0 (honoured in IDLE or HALT only)
//   load_en    program-memory write strobe (honoured in IDLE or HALT only)
//   load_addr  program-memory write address
//   load_data  program-memory write data
//   a          head-of-queue instruction (registered)
//   a_valid    a holds a valid instruction (registered)
//   a_ready    execute stage accepts a this cycle
//   pc         address of the next read to be issued
//   count      current queue occupancy
//   busy       high in RUN or DRAIN
//   halted     high in HALT
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 16,
  localparam int AW = $clog2(MEM_WORDS),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [31:0]   a,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [AW-1:0] pc,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          halted
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state;
  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   q   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          inflight;
  logic [31:0]   rd_data;

  logic          idle_like;
  logic          deq;
  logic          ret;
  logic          halt_ret;
  logic          enq;
  logic          issue;
  logic [CW-1:0] cnt_after_deq;
  logic [CW-1:0] count_nxt;
  logic [PW-1:0] head_nxt;

  // Handshake, read-return and issue decisions for the current cycle.
  always_comb begin
    idle_like = (state == IDLE) || (state == HALT);
    deq       = (count != {CW{1'b0}}) && a_ready;
    // inflight can only be set while in RUN; the state term keeps it explicit.
    ret       = inflight && (state == RUN);
    halt_ret  = ret && (rd_data == HALT_WORD);
    enq       = ret && !halt_ret;
    // The issue test counts the outstanding read so the queue can never
    // overflow when that read returns; a returning HALT word blocks issue.
    issue     = (state == RUN) && !halt_ret &&
                ((count + {{(CW-1){1'b0}}, inflight}) < CW'(DEPTH));
    if (deq) begin
      cnt_after_deq = count - CW'(1);
      head_nxt      = head + PW'(1);
    end else begin
      cnt_after_deq = count;
      head_nxt      = head;
    end
    if (enq) begin
      count_nxt = cnt_after_deq + CW'(1);
    end else begin
      count_nxt = cnt_after_deq;
    end
  end

  // Program-memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && load_en && idle_like) begin
      mem[load_addr] <= load_data;
    end
  end

  // Program-memory read port, one-cycle latency; inflight qualifies rd_data.
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_data <= mem[pc];
    end
  end

  // Queue storage; occupancy is tracked by count, so stale entries are harmless.
  always_ff @(posedge clk) begin
    if (enq) begin
      q[tail] <= rd_data;
    end
  end

  // Control FSM, queue pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= {AW{1'b0}};
      count    <= {CW{1'b0}};
      head     <= {PW{1'b0}};
      tail     <= {PW{1'b0}};
      inflight <= 1'b0;
      a        <= 32'h0000_0000;
      a_valid  <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      head     <= head_nxt;
      count    <= count_nxt;
      a_valid  <= (count_nxt != {CW{1'b0}});
      inflight <= issue;
      if (enq) begin
        tail <= tail + PW'(1);
      end
      // Present the next head; when the queue is momentarily empty after the
      // dequeue, the head is the word being enqueued this cycle. An empty
      // queue leaves a at its last value.
      if (count_nxt != {CW{1'b0}}) begin
        if (cnt_after_deq == {CW{1'b0}}) begin
          a <= rd_data;
        end else begin
          a <= q[head_nxt];
        end
      end
      // pc wraps naturally because MEM_WORDS is a power of two.
      if (issue) begin
        pc <= pc + AW'(1);
      end
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state  <= RUN;
            pc     <= {AW{1'b0}};
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        RUN: begin
          // The HALT word and the read carrying it are dropped (issue and
          // enq are both low), so only already-queued words drain.
          if (halt_ret) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (count == {CW{1'b0}}) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of instruction-queue entries (power of 2, at least 2).
REQ-002 Parameter: MEM_WORDS, 16, program-memory words; address width AW = log2(MEM_WORDS).
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  begin fetching at address 0; honoured only in IDLE or HALT.
REQ-006 Port: load_en  input  1  program-memory write strobe.
REQ-007 Port: load_addr  input  AW  program-memory write address.
REQ-008 Port: load_data  input  32  program-memory write data.
REQ-009 Port: a  output  32  head-of-queue instruction, feeding the execute stage instruction input.
REQ-010 Port: a_valid  output  1  a holds a valid instruction.
REQ-011 Port: a_ready  input  1  execute stage accepts a this cycle.
REQ-012 Port: pc  output  AW  address of the next read to be issued.
REQ-013 Port: count  output  log2(DEPTH)+1  current queue occupancy.
REQ-014 Port: busy  output  1  high in RUN or DRAIN.
REQ-015 Port: halted  output  1  high in HALT.

Function
REQ-016 Program memory: MEM_WORDS x 32, one write port, one read port; reads are synchronous with 1-cycle latency.
REQ-017 load_en writes load_data to load_addr only in IDLE or HALT; load_en is ignored in RUN and DRAIN.
REQ-018 States: IDLE, RUN, DRAIN, HALT.
REQ-019 IDLE -> RUN on start=1; pc cleared to 0.
REQ-020 HALT -> RUN on start=1; pc cleared to 0.
REQ-021 In RUN, a read of pc is issued when count + inflight < DEPTH (inflight is 0 or 1); pc then increments.
REQ-022 pc wraps modulo MEM_WORDS; MEM_WORDS-1 is followed by 0.
REQ-023 Returned read data is enqueued one cycle after issue, unless the data is the HALT word.
REQ-024 HALT word = 32'h0000_0000.
REQ-025 HALT word returned: the word is discarded, any in-flight read is discarded, and the state goes to DRAIN.
REQ-026 DRAIN issues no reads and goes to HALT in the cycle after count reaches 0 with no dequeue pending.
REQ-027 Handshake: a transfer occurs when a_valid and a_ready are both high; the queue head advances on that edge.
REQ-028 a and a_valid depend on registered state only, not combinationally on a_ready.
REQ-029 a_valid = (count != 0); a is held stable while a_valid=1 and a_ready=0.
REQ-030 Timing: start sampled at edge E0 -> read of address 0 issued in the cycle after E0 -> a_valid=1 with a=mem[0] after edge E2.
REQ-031 Simultaneous enqueue and dequeue leaves count unchanged and is legal at count=DEPTH.
REQ-032 With a_ready held high and no HALT word, one instruction per cycle is sustained.
REQ-033 Full: no read issued while count + inflight = DEPTH; no entry is ever overwritten or dropped.
REQ-034 Empty: a_valid=0 and a holds its last value; a dequeue while empty has no effect.
REQ-035 start while in RUN or DRAIN is ignored.

Reset
REQ-036 reset=1 at a rising edge forces IDLE with a=0, a_valid=0, pc=0, count=0, busy=0, halted=0, and any in-flight read discarded.
REQ-037 Reset has priority over start, load_en and the handshake in the same cycle.
REQ-038 Program-memory contents are not affected by reset.
REQ-039 Reset mid-RUN or mid-DRAIN empties the queue immediately.

Verification
REQ-040 Load mem[0..3] = 80000000, 80000010, 00400010, 00000000; pulse start; a_ready=1 -> a = 80000000, 80000010, 00400010 on consecutive cycles from E2; then busy=0, halted=1, pc=3 or 4.
REQ-041 Load 16 nonzero words; start; a_ready=0 -> count saturates at 4, a=mem[0] held, pc=4; then a_ready=1 -> mem[4..] stream in order with no gaps.
REQ-042 Full RUN with all 16 nonzero words -> after mem[15], a=mem[0] (pc wrap); load_en asserted during RUN leaves memory unchanged.
REQ-043 Toggle a_ready 1,0,1,0 in RUN -> a advances only on cycles where a_valid and a_ready are both high; no instruction is duplicated or lost.
REQ-044 Assert reset while count=3 in RUN -> next cycle a_valid=0, count=0, pc=0, busy=0; a new start restarts from mem[0].
REQ-045 From HALT, reload mem[0]=80000008, mem[1]=0 and pulse start -> exactly one instruction 80000008 is delivered, then HALT.
